// File: rtl/us_shot_scheduler_pkg.sv
// Shared constants for the ultrasonic shot scheduler: register map,
// FSM encoding and the read value returned for unmapped addresses.
package us_sched_pkg;

  localparam logic [7:0] CTRL      = 8'h00;
  localparam logic [7:0] FIRE_TIME = 8'h01;
  localparam logic [7:0] PULSE_LEN = 8'h02;
  localparam logic [7:0] PERIOD    = 8'h03;
  localparam logic [7:0] SHOTS     = 8'h04;
  localparam logic [7:0] WINDOW    = 8'h05;
  localparam logic [7:0] TX_TS     = 8'h06;
  localparam logic [7:0] ECHO_BASE = 8'h10;

  localparam logic [31:0] DEFAULT_RDATA = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    FIRE   = 3'd2,
    LISTEN = 3'd3,
    GAP    = 3'd4
  } state_t;

  function automatic logic [31:0] max_u32(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/us_shot_scheduler_if.sv
// Avalon-MM register port of the shot scheduler; the scheduler is the slave.
interface us_shot_scheduler_if;
  logic [15:0] address;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;
  logic        waitrequest;

  modport slave  (input address, write, writedata, read, output readdata, waitrequest);
  modport master (output address, write, writedata, read, input readdata, waitrequest);
endinterface

// File: rtl/us_shot_scheduler_echo_capture.sv
// One echo receiver: 2-flop synchroniser, registered rising-edge detect and a
// first-edge-per-shot timestamp latch (3 clocks pin-to-timestamp latency).
module echo_capture (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_echo,
  input  logic        i_arm,
  input  logic        i_enable,
  input  logic [31:0] i_time_cnt,
  output logic        o_seen,
  output logic [31:0] o_ts
);
  logic [1:0]  r_sync;
  logic        r_prev;
  logic        r_rise;
  logic        r_seen;
  logic [31:0] r_ts;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
      r_seen <= 1'b0;
      r_ts   <= '0;
    end else begin
      r_sync <= {r_sync[0], i_echo};
      r_prev <= r_sync[1];
      r_rise <= r_sync[1] & ~r_prev;
      if (i_arm) begin
        r_seen <= 1'b0;
      end else if (r_rise && i_enable && !r_seen) begin
        r_seen <= 1'b1;
        r_ts   <= i_time_cnt;
      end
    end
  end

  assign o_seen = r_seen;
  assign o_ts   = r_ts;
endmodule

// File: rtl/us_shot_scheduler.sv
// Ultrasonic shot scheduler: fires piezo bursts against the RTC counter and
// timestamps receiver echoes per shot; configured over Avalon-MM.
//   state  | meaning
//   IDLE   | no sequence running, config writable
//   ARMED  | waiting for time_cnt to reach FIRE_TIME
//   FIRE   | piezo enable high for PULSE_LEN clocks
//   LISTEN | echo window open until max(WINDOW, PULSE_LEN)
//   GAP    | waiting for PERIOD before the next shot
module us_shot_scheduler
  import us_sched_pkg::*;
#(
  parameter int N_RX = 4
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic [31:0]         i_time_cnt,
  input  logic [N_RX-1:0]     i_echo,
  us_shot_scheduler_if.slave  avs,
  output logic                o_piezo_enable,
  output logic                o_busy,
  output logic                o_irq
);
  localparam int CTRL_W = 21 + N_RX;

  state_t      r_state, w_next;
  logic [31:0] r_fire_time, r_pulse_len, r_period, r_window, r_tx_ts, r_shot_cnt, r_rdata;
  logic [15:0] r_shots, r_shots_left;
  logic        r_done, r_aborted, r_irq, r_piezo, r_rd_done;

  logic [N_RX-1:0] w_rx_mask;
  logic [31:0]     w_echo_ts [N_RX];
  logic [7:0]      w_idx;
  logic            w_start, w_abort, w_irq_clr, w_due, w_period_hit;
  logic            w_shot_start, w_enable, w_seq_done, w_zero_start;
  logic [31:0]     w_pulse_eff, w_listen_end, w_diff, w_rdata;
  logic [CTRL_W-1:0] w_ctrl;
  logic            w_unused;

  assign w_idx        = avs.address[15:8];
  assign w_unused     = ^avs.address[7:0];
  assign w_start      = avs.write && (w_idx == CTRL) && avs.writedata[0];
  assign w_abort      = avs.write && (w_idx == CTRL) && avs.writedata[1];
  assign w_irq_clr    = avs.write && (w_idx == CTRL) && avs.writedata[2];
  assign w_pulse_eff  = (r_pulse_len == '0) ? 32'd1 : r_pulse_len;
  assign w_listen_end = max_u32(r_window, w_pulse_eff);
  // Sign of the wrapped difference makes the fire compare wrap-safe.
  assign w_diff       = i_time_cnt - r_fire_time;
  assign w_due        = ~w_diff[31];
  // Counter is 0 the cycle after a shot start, so +1 spaces shot starts by PERIOD.
  assign w_period_hit = ({1'b0, r_shot_cnt} + 33'd1) >= {1'b0, r_period};

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_piezo <= 1'b0;
    end else begin
      r_state <= w_next;
      r_piezo <= (w_next == FIRE);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start && r_shots != '0) w_next = ARMED;
      ARMED:   if (w_due) w_next = FIRE;
      FIRE:    if (r_shot_cnt >= w_pulse_eff - 32'd1) w_next = LISTEN;
      LISTEN:  if (r_shot_cnt >= w_listen_end) w_next = (r_shots_left != '0) ? GAP : IDLE;
      GAP:     if (w_period_hit) w_next = FIRE;
      default: w_next = IDLE;
    endcase
    if (w_abort) w_next = IDLE;
  end

  always_comb begin
    o_busy       = (r_state != IDLE);
    w_enable     = (r_state == FIRE) || (r_state == LISTEN);
    w_shot_start = (w_next == FIRE) && ((r_state == ARMED) || (r_state == GAP));
    w_seq_done   = (r_state == LISTEN) && (w_next == IDLE) && !w_abort;
    w_zero_start = (r_state == IDLE) && w_start && !w_abort && (r_shots == '0);
  end

  assign o_piezo_enable = r_piezo;
  assign o_irq          = r_irq;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_fire_time  <= '0;
      r_pulse_len  <= '0;
      r_period     <= '0;
      r_window     <= '0;
      r_shots      <= '0;
      r_shots_left <= '0;
      r_tx_ts      <= '0;
      r_shot_cnt   <= '0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
      r_irq        <= 1'b0;
    end else begin
      if (avs.write && r_state == IDLE) begin
        case (w_idx)
          FIRE_TIME: r_fire_time <= avs.writedata;
          PULSE_LEN: r_pulse_len <= avs.writedata;
          PERIOD:    r_period    <= avs.writedata;
          SHOTS:     r_shots     <= avs.writedata[15:0];
          WINDOW:    r_window    <= avs.writedata;
          default:   ;
        endcase
      end

      if (w_shot_start)              r_shot_cnt <= '0;
      else if (r_shot_cnt != '1)     r_shot_cnt <= r_shot_cnt + 32'd1;

      if (w_abort)                             r_shots_left <= '0;
      else if (r_state == IDLE && w_start)     r_shots_left <= r_shots;
      else if (w_shot_start)                   r_shots_left <= r_shots_left - 16'd1;

      if (w_shot_start) r_tx_ts <= i_time_cnt;

      if (w_abort) begin
        r_aborted <= 1'b1;
      end else if (r_state == IDLE && w_start) begin
        r_aborted <= 1'b0;
        r_done    <= (r_shots == '0);
      end else if (w_seq_done) begin
        r_done <= 1'b1;
      end

      if (w_abort || w_seq_done || w_zero_start) r_irq <= 1'b1;
      else if (w_irq_clr)                        r_irq <= 1'b0;
    end
  end

  for (genvar g = 0; g < N_RX; g++) begin : g_echo
    echo_capture u_echo (
      .i_clock    (i_clock),
      .i_reset    (i_reset),
      .i_echo     (i_echo[g]),
      .i_arm      (w_shot_start),
      .i_enable   (w_enable),
      .i_time_cnt (i_time_cnt),
      .o_seen     (w_rx_mask[g]),
      .o_ts       (w_echo_ts[g])
    );
  end

  assign w_ctrl = {r_state, r_aborted, r_done, w_rx_mask, r_shots_left};

  always_comb begin
    w_rdata = DEFAULT_RDATA;
    case (w_idx)
      CTRL:      w_rdata = {{(32-CTRL_W){1'b0}}, w_ctrl};
      FIRE_TIME: w_rdata = r_fire_time;
      PULSE_LEN: w_rdata = r_pulse_len;
      PERIOD:    w_rdata = r_period;
      SHOTS:     w_rdata = {16'd0, r_shots};
      WINDOW:    w_rdata = r_window;
      TX_TS:     w_rdata = r_tx_ts;
      default: begin
        for (int i = 0; i < N_RX; i++) begin
          if (w_idx == ECHO_BASE + 8'(i)) w_rdata = w_echo_ts[i];
        end
      end
    endcase
  end

  // Every read stalls one cycle while the mux result is registered.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_rd_done <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_rd_done <= avs.read & ~r_rd_done;
      if (avs.read && !r_rd_done) r_rdata <= w_rdata;
    end
  end

  assign avs.readdata    = r_rdata;
  assign avs.waitrequest = avs.read & ~r_rd_done;
endmodule

// File: tb/tb_us_shot_scheduler.sv
// Directed bench for us_shot_scheduler: single shot with echoes, burst, wrap,
// past fire time, abort, zero-shot start and asynchronous reset.
module tb_us_shot_scheduler;
  import us_sched_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] time_cnt = '0;
  logic [3:0]  echo = '0;
  logic        piezo, busy, irq;
  logic        ld_en = 1'b0;
  logic [31:0] ld_val = '0;
  int          n_checks = 0;
  int          n_fail = 0;

  us_shot_scheduler_if avm ();

  us_shot_scheduler #(.N_RX(4)) dut (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_time_cnt     (time_cnt),
    .i_echo         (echo),
    .avs            (avm),
    .o_piezo_enable (piezo),
    .o_busy         (busy),
    .o_irq          (irq)
  );

  always #10 clk = ~clk;

  // RTC model: increments just after each rising edge, optionally reloaded.
  always begin
    @(posedge clk);
    #1;
    time_cnt = ld_en ? ld_val : time_cnt + 32'd1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_time(input logic [31:0] v);
    @(negedge clk);
    ld_val = v;
    ld_en  = 1'b1;
    @(posedge clk);
    #2 ld_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_tc(input logic [31:0] v);
    int n = 0;
    while (time_cnt != v && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("wait_tc", time_cnt, v);
  endtask

  task automatic avm_write(input logic [7:0] a, input logic [31:0] d);
    avm.address   = {a, 8'h3C};
    avm.writedata = d;
    avm.write     = 1'b1;
    @(negedge clk);
    avm.write     = 1'b0;
  endtask

  task automatic avm_read(input logic [7:0] a, output logic [31:0] d, output int waits);
    avm.address = {a, 8'hA5};
    avm.read    = 1'b1;
    waits       = 0;
    #1;
    while (avm.waitrequest && waits < 4) begin
      waits++;
      @(negedge clk);
      #1;
    end
    d        = avm.readdata;
    avm.read = 1'b0;
    @(negedge clk);
  endtask

  task automatic read_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] d;
    int w;
    avm_read(a, d, w);
    chk(tag, d, exp);
  endtask

  initial begin
    logic [31:0] first, last, d;
    logic [31:0] rises [4];
    int hi, guard, nr, w;
    logic prev;

    avm.address = '0; avm.write = 1'b0; avm.writedata = '0; avm.read = 1'b0;
    #55;
    chk("rst_piezo", 32'(piezo), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_irq", 32'(irq), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rdata", avm.readdata, 0);
    read_chk("rst_ctrl", CTRL, 32'h0);
    read_chk("rst_fire", FIRE_TIME, 32'h0);
    read_chk("unmapped_08", 8'h08, 32'hDEAD_BEEF);
    read_chk("unmapped_14", 8'h14, 32'hDEAD_BEEF);
    read_chk("rst_echo3", 8'h13, 32'h0);

    // Single shot with echoes
    set_time(32'd800);
    avm_write(FIRE_TIME, 32'd1000);
    avm_write(PULSE_LEN, 32'd10);
    avm_write(WINDOW, 32'd500);
    avm_write(SHOTS, 32'd1);
    wait_tc(32'd900);
    avm_write(CTRL, 32'h1);
    chk("s1_busy_start", 32'(busy), 1);
    first = 0; last = 0; hi = 0; guard = 0;
    while (time_cnt != 32'd1610 && guard < 2000) begin
      if (piezo) begin
        hi++;
        if (first == 0) first = time_cnt;
        last = time_cnt;
      end
      case (time_cnt)
        32'd1200, 32'd1300: echo[2] = 1'b1;
        32'd1202, 32'd1302: echo[2] = 1'b0;
        32'd1600:           echo[0] = 1'b1;
        32'd1602:           echo[0] = 1'b0;
        32'd1501: begin chk("s1_irq_pre", 32'(irq), 0); chk("s1_busy_pre", 32'(busy), 1); end
        32'd1502: begin chk("s1_irq_post", 32'(irq), 1); chk("s1_busy_post", 32'(busy), 0); end
        default: ;
      endcase
      @(negedge clk);
      guard++;
    end
    chk("s1_loop", time_cnt, 32'd1610);
    chk("s1_first", first, 32'd1001);
    chk("s1_last", last, 32'd1010);
    chk("s1_width", 32'(hi), 32'd10);
    read_chk("s1_tx_ts", TX_TS, 32'd1000);
    read_chk("s1_echo2", 8'h12, 32'd1203);
    read_chk("s1_echo0", 8'h10, 32'd0);
    read_chk("s1_ctrl", CTRL, 32'h0014_0000);
    avm_write(CTRL, 32'h4);
    chk("s1_irq_clr", 32'(irq), 0);

    // Burst of three shots
    set_time(32'd9900);
    avm_write(FIRE_TIME, 32'd10000);
    avm_write(SHOTS, 32'd3);
    avm_write(PERIOD, 32'd2000);
    wait_tc(32'd9950);
    avm_write(CTRL, 32'h1);
    nr = 0; hi = 0; guard = 0; prev = 1'b0;
    for (int i = 0; i < 4; i++) rises[i] = '0;
    while (time_cnt != 32'd15600 && guard < 8000) begin
      if (piezo) hi++;
      if (piezo && !prev && nr < 4) begin
        rises[nr] = time_cnt;
        nr++;
      end
      prev = piezo;
      case (time_cnt)
        32'd10100: echo[1] = 1'b1;
        32'd10102: echo[1] = 1'b0;
        32'd13000: echo[0] = 1'b1;
        32'd13002: echo[0] = 1'b0;
        32'd14100: echo[3] = 1'b1;
        32'd14102: echo[3] = 1'b0;
        32'd12502: begin chk("b_busy_mid", 32'(busy), 1); chk("b_irq_mid", 32'(irq), 0); end
        32'd14501: chk("b_irq_pre", 32'(irq), 0);
        32'd14502: begin chk("b_irq_post", 32'(irq), 1); chk("b_busy_post", 32'(busy), 0); end
        default: ;
      endcase
      @(negedge clk);
      guard++;
    end
    chk("b_loop", time_cnt, 32'd15600);
    chk("b_nshots", 32'(nr), 32'd3);
    chk("b_rise0", rises[0], 32'd10001);
    chk("b_rise1", rises[1], 32'd12001);
    chk("b_rise2", rises[2], 32'd14001);
    chk("b_width", 32'(hi), 32'd30);
    read_chk("b_tx_ts", TX_TS, 32'd14000);
    read_chk("b_ctrl", CTRL, 32'h0018_0000);
    read_chk("b_echo1", 8'h11, 32'd10103);
    read_chk("b_echo3", 8'h13, 32'd14103);
    read_chk("b_echo0", 8'h10, 32'd0);
    avm_write(CTRL, 32'h4);

    // Fire time just past the counter wrap
    avm_write(FIRE_TIME, 32'h0000_0005);
    avm_write(SHOTS, 32'd1);
    set_time(32'hFFFF_FFE0);
    wait_tc(32'hFFFF_FFF0);
    avm_write(CTRL, 32'h1);
    first = 32'hFFFF_FFFF; guard = 0;
    while (time_cnt != 32'd30 && guard < 100) begin
      if (piezo && first == 32'hFFFF_FFFF) first = time_cnt;
      @(negedge clk);
      guard++;
    end
    chk("w_first_pulse", first, 32'd6);
    guard = 0;
    while (busy && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    chk("w_done_busy", 32'(busy), 0);
    read_chk("w_tx_ts", TX_TS, 32'd5);
    avm_write(CTRL, 32'h4);

    // Fire time in the past, then abort during FIRE
    avm_write(FIRE_TIME, 32'd2000);
    set_time(32'd2090);
    wait_tc(32'd2100);
    avm_write(CTRL, 32'h1);
    chk("p_piezo_arm", 32'(piezo), 0);
    chk("p_busy_arm", 32'(busy), 1);
    @(negedge clk);
    chk("p_piezo_fire", 32'(piezo), 1);
    @(negedge clk);
    avm_write(PULSE_LEN, 32'd77);
    chk("a_piezo_before", 32'(piezo), 1);
    avm_write(CTRL, 32'h2);
    chk("a_piezo_after", 32'(piezo), 0);
    chk("a_busy", 32'(busy), 0);
    chk("a_irq", 32'(irq), 1);
    read_chk("p_tx_ts", TX_TS, 32'd2101);
    read_chk("a_ctrl", CTRL, 32'h0020_0000);
    read_chk("a_plen_kept", PULSE_LEN, 32'd10);
    avm_write(PULSE_LEN, 32'd77);
    read_chk("a_plen_new", PULSE_LEN, 32'd77);

    // Abort and start in one write: abort wins
    avm_write(CTRL, 32'h4);
    avm_write(CTRL, 32'h3);
    chk("as_busy", 32'(busy), 0);
    chk("as_irq", 32'(irq), 1);
    read_chk("as_ctrl", CTRL, 32'h0020_0000);

    // Start with zero shots
    avm_write(CTRL, 32'h4);
    avm_write(SHOTS, 32'd0);
    avm_write(CTRL, 32'h1);
    chk("z_busy", 32'(busy), 0);
    chk("z_irq", 32'(irq), 1);
    read_chk("z_ctrl", CTRL, 32'h0010_0000);

    // Asynchronous reset during LISTEN
    avm_write(SHOTS, 32'd1);
    avm_write(FIRE_TIME, 32'd3000);
    set_time(32'd2990);
    wait_tc(32'd2995);
    avm_write(CTRL, 32'h1);
    wait_tc(32'd3200);
    read_chk("r_tx_ts", TX_TS, 32'd3000);
    chk("r_busy_pre", 32'(busy), 1);
    #3 rst = 1'b1;
    #1;
    chk("r_piezo", 32'(piezo), 0);
    chk("r_busy", 32'(busy), 0);
    chk("r_irq", 32'(irq), 0);
    chk("r_rdata", avm.readdata, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    avm_read(CTRL, d, w);
    chk("r_ctrl_waits", 32'(w), 32'd1);
    chk("r_ctrl", d, 32'h0);
    read_chk("r_plen", PULSE_LEN, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
